demux_n1x4_pkt: RTL and testbench
=================================

Name: demux_n1x4_pkt

Overview:
- Registered 1-to-4 packet demultiplexer with valid/ready handshakes on every port.
- Steers a single input stream to one of four output channels, selected by a 2-bit select.
- Select is sampled at the first beat of each packet and held until that packet's last beat.
- Sits on the distribution side of a datapath, opposite the 4:1 select muxes that gather channels back into one; it uses the same select encoding.

Parameters:
- WIDTH, 1, data width of the input and of each output channel.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i  input  WIDTH  input data beat.
- i_valid  input  1  input beat present.
- i_last  input  1  beat is the final beat of its packet; qualified by i_valid.
- i_ready  output  1  block accepts the beat this cycle.
- sel0  input  1  select bit 0; sampled on the first beat only.
- sel1  input  1  select bit 1; sampled on the first beat only.
- o0, o1, o2, o3  output  WIDTH each  channel data; registered.
- o0_valid, o1_valid, o2_valid, o3_valid  output  1 each  channel beat present.
- o0_last, o1_last, o2_last, o3_last  output  1 each  channel beat is a packet end.
- o0_ready, o1_ready, o2_ready, o3_ready  input  1 each  downstream accepts the channel beat.
- busy  output  1  high while a packet is open (state PKT).

Behaviour:
- Reset is asynchronous on rst_n low and release is synchronous to clk. While rst_n is low:
  - state = IDLE and the latched select = 2'b00.
  - all oN_valid = 0, oN_last = 0, oN = 0, busy = 0.
  - i_ready = 0.
- Select encoding is {sel1,sel0}: 00 -> channel 0, 01 -> channel 1, 10 -> channel 2, 11 -> channel 3.
- Target channel:
  - In IDLE, target = live {sel1,sel0}.
  - In PKT, target = the latched select.
- Each channel has a one-entry output register (data, last, valid).
- i_ready = rst_n && (!oT_valid || oT_ready), where T is the target channel. i_ready is combinational.
- A transfer occurs when i_valid && i_ready. On transfer:
  - oT <= i, oT_last <= i_last, oT_valid <= 1 on the next edge.
  - Latency from input transfer to output valid is 1 cycle.
  - Full throughput: one beat per cycle when the target's downstream holds oT_ready = 1.
- For each channel N: if oN_valid && oN_ready and there is no new transfer into N, then oN_valid <= 0 next edge.
- A drain and a refill of the same channel in the same cycle is a legal back-to-back transfer: valid stays 1 and the data is replaced.
- oN and oN_last hold their last value when oN_valid = 0.
- Non-target channels drain independently. Several oN_valid may be high at once when earlier packets are still pending.
- State machine:
  - IDLE: on a transfer with i_last = 0, latch {sel1,sel0} and go to PKT. On a transfer with i_last = 1 (single-beat packet), stay in IDLE and latch nothing.
  - PKT: sel0/sel1 are ignored. On a transfer with i_last = 1, go to IDLE. Otherwise stay.
  - busy = (state == PKT).
- Boundary conditions:
  - Select changes mid-packet have no effect.
  - i_valid low mid-packet leaves the block in PKT indefinitely, with no timeout.
  - A target register that is full with oT_ready = 0 deasserts i_ready. i_* must be held stable by upstream; the block keeps no input buffer.
  - Reset mid-packet drops all pending channel beats and returns to IDLE.
- No X propagation from unselected channel ready inputs into i_ready.

Test Plan:
- Reset, then single-beat packets: sel = 10, i = 8'hA5, i_last = 1, all oN_ready = 1. Required: i_ready = 1; o2 = 8'hA5, o2_valid = 1, o2_last = 1 exactly one cycle later; other valids stay 0; busy stays 0.
- Select lock: 4-beat packet 8'h01..8'h04 started with sel = 01, sel toggled to 11 after beat 1. Required: all four beats appear on o1 in consecutive cycles; o1_last = 1 only with 8'h04; o3_valid never 1; busy = 1 from after beat 1 until after beat 4.
- Backpressure: packet to channel 0 with o0_ready = 0 for 3 cycles. Required: o0_valid = 1 holding beat 1; i_ready = 0 for those cycles. After o0_ready rises, the remaining beats flow one per cycle with no loss or duplication.
- Independent channels: channel 0 holds an undrained beat (o0_ready = 0); a new single-beat packet with sel = 11 is sent. Required: i_ready = 1; o3_valid = 1 next cycle while o0_valid stays 1 with unchanged data.
- Reset mid-packet: rst_n pulsed low asynchronously mid-clock after beat 2 of a 5-beat packet to channel 2. Required: o2_valid, o2_last, busy and i_ready go to 0 immediately. After release, a sel = 00 single-beat packet goes to channel 0, proving the FSM returned to IDLE.
- Back-to-back refill: continuous 8-beat packet to channel 1 with o1_ready held 1. Required: o1_valid is continuously 1 for 8 cycles, with data sequence matching input order.

Source files
------------

// File: rtl/demux_n1x4_pkt.sv
// Registered 1-to-4 packet demultiplexer: the select is captured on the first
// beat of a packet and steers every beat of that packet to one output register.
module demux_n1x4_pkt #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  input  logic             i_valid,
  input  logic             i_last,
  output logic             i_ready,
  input  logic             sel0,
  input  logic             sel1,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic             o0_valid,
  output logic             o1_valid,
  output logic             o2_valid,
  output logic             o3_valid,
  output logic             o0_last,
  output logic             o1_last,
  output logic             o2_last,
  output logic             o3_last,
  input  logic             o0_ready,
  input  logic             o1_ready,
  input  logic             o2_ready,
  input  logic             o3_ready,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_sel;
  logic [1:0]       w_tgt;
  logic             w_xfer;
  logic [3:0]       w_oready;
  logic [3:0]       w_valid;
  logic [3:0]       w_last;
  logic [WIDTH-1:0] w_data [4];

  assign w_oready = {o3_ready, o2_ready, o1_ready, o0_ready};

  // Indexing by the target keeps unselected ready inputs out of i_ready.
  assign w_tgt   = (r_state == PKT) ? r_sel : {sel1, sel0};
  assign i_ready = rst_n && (!w_valid[w_tgt] || w_oready[w_tgt]);
  assign w_xfer  = i_valid && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 2'b00;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_xfer && !i_last) begin
        r_sel <= {sel1, sel0};
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_xfer && !i_last) w_state_next = PKT;
      PKT:     if (w_xfer && i_last)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == PKT);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_last;

    // A refill in the same cycle as a drain takes priority and keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data  <= '0;
        r_last  <= 1'b0;
        r_valid <= 1'b0;
      end else if (w_xfer && (w_tgt == 2'(gi))) begin
        r_data  <= i;
        r_last  <= i_last;
        r_valid <= 1'b1;
      end else if (r_valid && w_oready[gi]) begin
        r_valid <= 1'b0;
      end
    end

    assign w_data[gi]  = r_data;
    assign w_valid[gi] = r_valid;
    assign w_last[gi]  = r_last;
  end

  assign o0 = w_data[0];
  assign o1 = w_data[1];
  assign o2 = w_data[2];
  assign o3 = w_data[3];
  assign o0_valid = w_valid[0];
  assign o1_valid = w_valid[1];
  assign o2_valid = w_valid[2];
  assign o3_valid = w_valid[3];
  assign o0_last = w_last[0];
  assign o1_last = w_last[1];
  assign o2_last = w_last[2];
  assign o3_last = w_last[3];

endmodule

// File: tb/tb_demux_n1x4_pkt.sv
// Bench for demux_n1x4_pkt: packet-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized packets.
module tb_demux_n1x4_pkt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_d;
  logic       i_valid, i_last, sel0, sel1;
  logic       i_ready;
  logic [7:0] o_d [4];
  logic [3:0] o_v, o_l;
  logic [3:0] o_ready;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // Reference model: per-channel held beat, open-packet flag and locked channel.
  bit         m_full [4];
  logic [7:0] m_d    [4];
  logic       m_l    [4];
  bit         m_open;
  logic [1:0] m_lock;
  logic [1:0] m_tgt;
  bit         m_erdy;
  bit         acc;
  int         cyc_cnt = 0;
  bit         rand_en = 0;

  demux_n1x4_pkt #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i(i_d), .i_valid(i_valid), .i_last(i_last), .i_ready(i_ready),
    .sel0(sel0), .sel1(sel1),
    .o0(o_d[0]), .o1(o_d[1]), .o2(o_d[2]), .o3(o_d[3]),
    .o0_valid(o_v[0]), .o1_valid(o_v[1]), .o2_valid(o_v[2]), .o3_valid(o_v[3]),
    .o0_last(o_l[0]), .o1_last(o_l[1]), .o2_last(o_l[2]), .o3_last(o_l[3]),
    .o0_ready(o_ready[0]), .o1_ready(o_ready[1]), .o2_ready(o_ready[2]), .o3_ready(o_ready[3]),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: outputs checked against the model each falling edge,
  // then the model advances for the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        m_full[n] = 0; m_d[n] = 8'h00; m_l[n] = 1'b0;
        chk($sformatf("rst_ch%0d_valid", n), 32'(o_v[n]), 32'd0);
        chk($sformatf("rst_ch%0d_data", n), 32'(o_d[n]), 32'd0);
        chk($sformatf("rst_ch%0d_last", n), 32'(o_l[n]), 32'd0);
      end
      m_open = 0; m_lock = 2'b00; acc = 0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_i_ready", 32'(i_ready), 32'd0);
    end else begin
      cyc_cnt++;
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("ch%0d_valid", n), 32'(o_v[n]), 32'(m_full[n]));
        chk($sformatf("ch%0d_data", n), 32'(o_d[n]), 32'(m_d[n]));
        chk($sformatf("ch%0d_last", n), 32'(o_l[n]), 32'(m_l[n]));
      end
      chk("busy", 32'(busy), 32'(m_open));
      m_tgt  = m_open ? m_lock : {sel1, sel0};
      m_erdy = !m_full[m_tgt] || o_ready[m_tgt];
      chk("i_ready", 32'(i_ready), 32'(m_erdy));
      acc = i_valid && m_erdy;
      for (int n = 0; n < 4; n++)
        if (m_full[n] && o_ready[n]) m_full[n] = 0;
      if (acc) begin
        m_full[m_tgt] = 1; m_d[m_tgt] = i_d; m_l[m_tgt] = i_last;
        if (!m_open && !i_last) begin
          m_open = 1; m_lock = m_tgt;
        end else if (m_open && i_last) begin
          m_open = 0;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic [1:0] s);
    i_valid = v; i_d = d; i_last = l; {sel1, sel0} = s;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    if (rand_en)
      for (int n = 0; n < 4; n++) o_ready[n] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 8'($urandom), 1'($urandom), 2'($urandom));
    repeat (n) cyc();
  endtask

  // Holds the beat until the model reports acceptance; returns just after that edge.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic [1:0] s);
    bit done;
    int k;
    done = 0; k = 0;
    drive(1'b1, d, l, s);
    while (!done) begin
      @(posedge clk);
      done = acc;
      #1;
      if (rand_en)
        for (int n = 0; n < 4; n++) o_ready[n] = ($urandom_range(0, 3) != 0);
      k++;
      if (!done && k > 100) begin
        chk("accept_timeout", 32'd0, 32'd1);
        done = 1;
      end
    end
  endtask

  initial begin
    int len, ch, start;
    rst_n = 1'b0; o_ready = 4'hF;
    drive(1'b0, 8'h00, 1'b0, 2'b00);
    @(negedge clk); #1;
    chk("reset_i_ready", 32'(i_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valids", 32'(o_v), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    cyc();

    // Single-beat packet to channel 2
    drive(1'b1, 8'hA5, 1'b1, 2'b10);
    @(negedge clk);
    chk("single_i_ready", 32'(i_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 1'b0, 2'b00);
    @(negedge clk);
    chk("single_o2", 32'(o_d[2]), 32'hA5);
    chk("single_o2_valid", 32'(o_v[2]), 32'd1);
    chk("single_o2_last", 32'(o_l[2]), 32'd1);
    chk("single_other_valid", 32'({o_v[3], o_v[1], o_v[0]}), 32'd0);
    chk("single_busy", 32'(busy), 32'd0);
    cyc(); cyc();

    // Select lock: packet opened on channel 1, select moved to 3 mid-packet
    send_beat(8'h01, 1'b0, 2'b01);
    chk("lock_busy_open", 32'(busy), 32'd1);
    chk("lock_o1_b1", 32'(o_d[1]), 32'h01);
    send_beat(8'h02, 1'b0, 2'b11);
    send_beat(8'h03, 1'b0, 2'b11);
    chk("lock_o3_valid", 32'(o_v[3]), 32'd0);
    send_beat(8'h04, 1'b1, 2'b11);
    drive(1'b0, 8'h00, 1'b0, 2'b11);
    chk("lock_o1_b4", 32'(o_d[1]), 32'h04);
    chk("lock_o1_last", 32'(o_l[1]), 32'd1);
    chk("lock_busy_closed", 32'(busy), 32'd0);
    chk("lock_o3_valid_end", 32'(o_v[3]), 32'd0);
    cyc(); cyc();

    // Backpressure on channel 0
    o_ready = 4'b1110;
    drive(1'b1, 8'h10, 1'b0, 2'b00);
    @(negedge clk);
    chk("bp_first_ready", 32'(i_ready), 32'd1);
    cyc();
    drive(1'b1, 8'h11, 1'b0, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_i_ready", 32'(i_ready), 32'd0);
      chk("bp_o0_hold", 32'(o_d[0]), 32'h10);
      chk("bp_o0_valid", 32'(o_v[0]), 32'd1);
      cyc();
    end
    o_ready = 4'hF;
    send_beat(8'h11, 1'b0, 2'b00);
    send_beat(8'h12, 1'b0, 2'b10);
    send_beat(8'h13, 1'b1, 2'b01);
    idle(2);

    // Independent channels: channel 0 stalled, channel 3 still accepts
    o_ready = 4'b1110;
    send_beat(8'h5A, 1'b1, 2'b00);
    drive(1'b1, 8'h3C, 1'b1, 2'b11);
    @(negedge clk);
    chk("indep_i_ready", 32'(i_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 1'b0, 2'b00);
    chk("indep_o3_valid", 32'(o_v[3]), 32'd1);
    chk("indep_o3", 32'(o_d[3]), 32'h3C);
    chk("indep_o0_valid", 32'(o_v[0]), 32'd1);
    chk("indep_o0", 32'(o_d[0]), 32'h5A);
    o_ready = 4'hF;
    idle(2);

    // Asynchronous reset in the middle of a packet
    send_beat(8'h20, 1'b0, 2'b10);
    send_beat(8'h21, 1'b0, 2'b10);
    drive(1'b1, 8'h22, 1'b0, 2'b10);
    #2 rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 2'b00);
    #1;
    chk("mid_rst_o2_valid", 32'(o_v[2]), 32'd0);
    chk("mid_rst_o2_last", 32'(o_l[2]), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_i_ready", 32'(i_ready), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    cyc();
    send_beat(8'h77, 1'b1, 2'b00);
    drive(1'b0, 8'h00, 1'b0, 2'b10);
    chk("post_rst_o0", 32'(o_d[0]), 32'h77);
    chk("post_rst_o0_valid", 32'(o_v[0]), 32'd1);
    chk("post_rst_o2_valid", 32'(o_v[2]), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    idle(2);

    // Back-to-back refill: 8 beats on channel 1 in 8 cycles
    start = cyc_cnt;
    for (int k = 0; k < 8; k++)
      send_beat(8'h80 + 8'(k), (k == 7), (k == 0) ? 2'b01 : 2'($urandom));
    drive(1'b0, 8'h00, 1'b0, 2'b00);
    chk("b2b_cycles", 32'(cyc_cnt - start), 32'd8);
    chk("b2b_o1_end", 32'(o_d[1]), 32'h87);
    chk("b2b_o1_last", 32'(o_l[1]), 32'd1);
    idle(2);

    // Randomized packets with random downstream backpressure
    rand_en = 1;
    for (int p = 0; p < 40; p++) begin
      ch  = $urandom_range(0, 3);
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++)
        send_beat(8'($urandom), (b == len - 1), (b == 0) ? 2'(ch) : 2'($urandom));
      idle($urandom_range(0, 2));
    end
    rand_en = 0;
    o_ready = 4'hF;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
